// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and field positions.
package cp0_pkg;

    localparam logic [7:0] ADDR_BADVADDR = 8'd64;
    localparam logic [7:0] ADDR_COUNT    = 8'd72;
    localparam logic [7:0] ADDR_COMPARE  = 8'd88;
    localparam logic [7:0] ADDR_STATUS   = 8'd96;
    localparam logic [7:0] ADDR_CAUSE    = 8'd104;
    localparam logic [7:0] ADDR_EPC      = 8'd112;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exccode_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam int MAX_HW_INT = 6;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky TI flag.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             incd_r;   // Count was advanced by the divider on the last edge
    logic             wrap_s;

    assign wrap_s = (div_r == DIV_MAX);

    // Divider, Count, Compare and TI; software writes override the timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r   <= '0;
            incd_r  <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count  <= wdata;
                div_r  <= '0;
                incd_r <= 1'b0;
            end else begin
                div_r  <= wrap_s ? '0 : div_r + 1'b1;
                incd_r <= wrap_s;
                if (wrap_s) begin
                    count <= count + 32'd1;
                end else begin
                    count <= count;
                end
            end

            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (incd_r && (count == compare)) begin
                ti <= 1'b1;
            end else begin
                ti <= ti;
            end
        end
    end

endmodule

// File: rtl/cp0_timer_int.sv
// Architectural CP0 state beside WS: exception/ERET commit, MFC0/MTC0, interrupts and redirect.
module cp0_timer_int
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_valid,
    input  logic                  ws_excp,
    input  logic [4:0]            ws_excode,
    input  logic [31:0]           ws_pc,
    input  logic                  ws_bd,
    input  logic [31:0]           ws_badvaddr,
    input  logic                  ws_eret,
    input  logic                  mtc0_we,
    input  logic [7:0]            c0_addr,
    input  logic [31:0]           mtc0_wdata,
    output logic [31:0]           mfc0_rdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic                  int_pending,
    output logic                  flush,
    output logic [31:0]           flush_pc
);

    logic [31:0] badvaddr_r, epc_r;
    logic [7:0]  im_r;
    logic        exl_r, ie_r, bd_r;
    logic [4:0]  exccode_r;
    logic [1:0]  sw_ip_r;
    logic [MAX_HW_INT-1:0] hw_ip_r, hw_ext_s;
    logic [31:0] count_s, compare_s;
    logic        ti_s;
    logic        commit_exc_s, commit_eret_s, commit_mtc0_s;
    logic [7:0]  ip_s;
    logic [31:0] status_s, cause_s;

    // Lines beyond NUM_HW_INT read as zero in Cause.IP.
    for (genvar i = 0; i < MAX_HW_INT; i++) begin : g_hw
        if (i < NUM_HW_INT) begin : g_on
            assign hw_ext_s[i] = hw_int[i];
        end else begin : g_off
            assign hw_ext_s[i] = 1'b0;
        end
    end

    assign commit_exc_s  = ws_valid & ws_excp;
    assign commit_eret_s = ws_valid & ws_eret & ~ws_excp;
    assign commit_mtc0_s = ws_valid & mtc0_we & ~ws_excp & ~ws_eret;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (commit_mtc0_s && (c0_addr == ADDR_COUNT)),
        .compare_we (commit_mtc0_s && (c0_addr == ADDR_COMPARE)),
        .wdata      (mtc0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    assign ip_s     = {hw_ip_r[5] | ti_s, hw_ip_r[4:0], sw_ip_r};
    assign status_s = {9'd0, 1'b1, 6'd0, im_r, 6'd0, exl_r, ie_r};
    assign cause_s  = {bd_r, ti_s, 14'd0, ip_s, 1'b0, exccode_r, 2'd0};
    assign int_pending = ie_r & ~exl_r & (|(ip_s & im_r));

    // MFC0 read mux over pre-edge state.
    always_comb begin
        mfc0_rdata = 32'd0;
        case (c0_addr)
            ADDR_BADVADDR: mfc0_rdata = badvaddr_r;
            ADDR_COUNT:    mfc0_rdata = count_s;
            ADDR_COMPARE:  mfc0_rdata = compare_s;
            ADDR_STATUS:   mfc0_rdata = status_s;
            ADDR_CAUSE:    mfc0_rdata = cause_s;
            ADDR_EPC:      mfc0_rdata = epc_r;
            default:       mfc0_rdata = 32'd0;
        endcase
    end

    // Redirect for the commit cycle of an exception or ERET.
    always_comb begin
        flush    = 1'b0;
        flush_pc = 32'd0;
        if (reset) begin
            flush    = 1'b0;
            flush_pc = 32'd0;
        end else if (commit_exc_s) begin
            flush    = 1'b1;
            flush_pc = EXC_VECTOR;
        end else if (commit_eret_s) begin
            flush    = 1'b1;
            flush_pc = epc_r;
        end else begin
            flush    = 1'b0;
            flush_pc = 32'd0;
        end
    end

    // Architectural state update; a nested exception keeps the original EPC/BD.
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_r <= 32'd0;
            epc_r      <= 32'd0;
            im_r       <= 8'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            exccode_r  <= 5'd0;
            sw_ip_r    <= 2'd0;
            hw_ip_r    <= '0;
        end else begin
            hw_ip_r <= hw_ext_s;
            if (commit_exc_s) begin
                if (!exl_r) begin
                    epc_r <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
                    bd_r  <= ws_bd;
                end
                exl_r     <= 1'b1;
                exccode_r <= ws_excode;
                if (is_addr_exc(ws_excode)) begin
                    badvaddr_r <= ws_badvaddr;
                end
            end else if (commit_eret_s) begin
                exl_r <= 1'b0;
            end else if (commit_mtc0_s) begin
                case (c0_addr)
                    ADDR_STATUS: begin
                        im_r  <= mtc0_wdata[STATUS_IM_LSB +: 8];
                        exl_r <= mtc0_wdata[STATUS_EXL];
                        ie_r  <= mtc0_wdata[STATUS_IE];
                    end
                    ADDR_CAUSE: sw_ip_r <= mtc0_wdata[CAUSE_IP_LSB +: 2];
                    ADDR_EPC:   epc_r   <= mtc0_wdata;
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer_int.sv
// Directed bench for cp0_timer_int: expected responses are queued by stimulus, checked by a monitor.
module tb_cp0_timer_int;
    import cp0_pkg::*;

    localparam logic [31:0] VEC = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_excp, ws_bd, ws_eret, mtc0_we;
    logic [4:0]  ws_excode;
    logic [31:0] ws_pc, ws_badvaddr, mtc0_wdata;
    logic [7:0]  c0_addr;
    logic [31:0] mfc0_rdata;
    logic [5:0]  hw_int;
    logic        int_pending, flush;
    logic [31:0] flush_pc;

    typedef struct {
        int          kind;   // 0: mfc0_rdata, 1: int_pending, 2: flush level
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] flush_q[$];
    logic        obs_en, flush_en;
    int          total = 0;
    int          bad   = 0;
    exp_t        e;
    logic [31:0] act, exp_pc;

    cp0_timer_int #(.NUM_HW_INT(6), .COUNT_DIV(2), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_excp(ws_excp),
        .ws_excode(ws_excode), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_badvaddr(ws_badvaddr),
        .ws_eret(ws_eret), .mtc0_we(mtc0_we), .c0_addr(c0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_rdata(mfc0_rdata), .hw_int(hw_int), .int_pending(int_pending),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    // Monitor: samples at negedge, pops expected values when an observation is due.
    always @(negedge clk) begin
        if (obs_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: got observation, want queued entry");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       act = mfc0_rdata;
                    1:       act = {31'd0, int_pending};
                    default: act = {31'd0, flush};
                endcase
                if (act !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.val);
                end
            end
        end
        if (flush_en || flush === 1'b1) begin
            total++;
            if (!flush_en) begin
                bad++;
                $display("FAIL unexpected_flush: got flush_pc %h want no flush", flush_pc);
            end else if (flush_q.size() == 0) begin
                bad++;
                $display("FAIL flush_underflow: got flush %b want queued target", flush);
            end else begin
                exp_pc = flush_q.pop_front();
                if (flush !== 1'b1 || flush_pc !== exp_pc) begin
                    bad++;
                    $display("FAIL flush_pc: got flush=%b pc=%h want flush=1 pc=%h", flush, flush_pc, exp_pc);
                end
            end
        end
    end

    task automatic idle();
        ws_valid = 1'b0; ws_excp = 1'b0; ws_eret = 1'b0; mtc0_we = 1'b0;
        ws_bd = 1'b0; ws_excode = 5'd0; obs_en = 1'b0; flush_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input int kind, input logic [31:0] v, input string n);
        obs_en = 1'b1;
        exp_q.push_back('{kind: kind, val: v, name: n});
        step();
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] v, input string n);
        c0_addr = a;
        chk(0, v, n);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        ws_valid = 1'b1; mtc0_we = 1'b1; c0_addr = a; mtc0_wdata = d;
        step();
    endtask

    task automatic excp(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                        input logic [31:0] bva, input logic also_eret);
        ws_valid = 1'b1; ws_excp = 1'b1; ws_eret = also_eret; ws_excode = code;
        ws_pc = pc; ws_bd = bd; ws_badvaddr = bva; flush_en = 1'b1;
        flush_q.push_back(VEC);
        step();
    endtask

    task automatic eret(input logic [31:0] target);
        ws_valid = 1'b1; ws_eret = 1'b1; flush_en = 1'b1;
        flush_q.push_back(target);
        step();
    endtask

    initial begin
        idle();
        reset = 1'b1; hw_int = 6'd0; c0_addr = 8'd0; mtc0_wdata = 32'd0;
        ws_pc = 32'd0; ws_badvaddr = 32'd0;
        #1;
        idle_n(2);
        ws_valid = 1'b1; ws_excp = 1'b1; ws_excode = 5'd8;
        chk(2, 32'd0, "flush_in_reset");
        reset = 1'b0;

        rd(ADDR_STATUS, 32'h0040_0000, "status_reset");
        rd(ADDR_CAUSE,  32'h0000_0000, "cause_reset");
        rd(ADDR_EPC,    32'h0000_0000, "epc_reset");
        chk(1, 32'd0, "int_reset");

        excp(5'd8, 32'hbfc0_0100, 1'b0, 32'd0, 1'b0);
        rd(ADDR_EPC,    32'hbfc0_0100, "epc_first");
        rd(ADDR_CAUSE,  32'h0000_0020, "cause_first");
        rd(ADDR_STATUS, 32'h0040_0002, "status_exl");

        excp(5'd10, 32'h8000_1000, 1'b1, 32'd0, 1'b0);
        rd(ADDR_EPC,    32'hbfc0_0100, "epc_nested");
        rd(ADDR_CAUSE,  32'h0000_0028, "cause_nested");
        eret(32'hbfc0_0100);
        rd(ADDR_STATUS, 32'h0040_0000, "status_after_eret");

        excp(5'd12, 32'h8000_2000, 1'b1, 32'd0, 1'b1);
        rd(ADDR_STATUS, 32'h0040_0002, "status_excp_eret");
        rd(ADDR_CAUSE,  32'h8000_0030, "cause_bd");
        rd(ADDR_EPC,    32'h8000_1ffc, "epc_bd");
        eret(32'h8000_1ffc);

        excp(5'd4, 32'h8000_3000, 1'b0, 32'h8000_0003, 1'b0);
        rd(ADDR_BADVADDR, 32'h8000_0003, "badvaddr_adel");
        eret(32'h8000_3000);
        excp(5'd5, 32'h8000_3200, 1'b0, 32'h0000_0ff1, 1'b0);
        rd(ADDR_BADVADDR, 32'h0000_0ff1, "badvaddr_ades");
        eret(32'h8000_3200);
        excp(5'd8, 32'h8000_3100, 1'b0, 32'h1234_5678, 1'b0);
        rd(ADDR_BADVADDR, 32'h0000_0ff1, "badvaddr_kept");
        eret(32'h8000_3100);
        mtc0(ADDR_BADVADDR, 32'hdead_beef);
        rd(ADDR_BADVADDR, 32'h0000_0ff1, "badvaddr_ro");
        mtc0(8'd8, 32'hffff_ffff);
        rd(8'd8, 32'h0000_0000, "unmapped_read");
        rd(ADDR_CAUSE, 32'h0000_0020, "cause_pre_timer");

        // Timer: Count written in cycle A, Compare in A+1, TI visible from A+8.
        mtc0(ADDR_COUNT, 32'd0);
        mtc0(ADDR_COMPARE, 32'd3);
        idle_n(5);
        rd(ADDR_CAUSE, 32'h0000_0020, "ti_not_yet");
        rd(ADDR_CAUSE, 32'h4000_8020, "ti_set");
        rd(ADDR_COUNT, 32'd4, "count_value");
        mtc0(ADDR_STATUS, 32'h0000_8001);
        chk(1, 32'd1, "int_timer");
        mtc0(ADDR_COMPARE, 32'h0100_0000);
        chk(1, 32'd0, "int_timer_cleared");
        rd(ADDR_CAUSE, 32'h0000_0020, "ti_cleared");

        mtc0(ADDR_STATUS, 32'h0000_0401);
        hw_int = 6'b000001;
        chk(1, 32'd0, "int_hw_same_cycle");
        chk(1, 32'd1, "int_hw_next_cycle");
        mtc0(ADDR_STATUS, 32'h0000_0403);
        hw_int = 6'b100001;
        chk(1, 32'd0, "int_masked_by_exl");
        rd(ADDR_CAUSE, 32'h0000_8420, "cause_hw_ip");
        hw_int = 6'b000000;
        mtc0(ADDR_CAUSE, 32'hffff_ffff);
        rd(ADDR_CAUSE, 32'h0000_0320, "cause_sw_ip");
        rd(ADDR_STATUS, 32'h0040_0403, "status_written");

        // Compare rewritten in the cycle that would set TI.
        mtc0(ADDR_COUNT, 32'd10);
        mtc0(ADDR_COMPARE, 32'd11);
        idle_n(1);
        mtc0(ADDR_COMPARE, 32'd11);
        rd(ADDR_CAUSE, 32'h0000_0320, "collision_ti0_a");
        rd(ADDR_CAUSE, 32'h0000_0320, "collision_ti0_b");

        mtc0(ADDR_COUNT, 32'd0);
        mtc0(ADDR_COMPARE, 32'd1);
        idle_n(2);
        rd(ADDR_CAUSE, 32'h4000_8320, "ti_before_reset");
        reset = 1'b1;
        ws_valid = 1'b1; ws_excp = 1'b1; ws_excode = 5'd8;
        chk(2, 32'd0, "flush_mid_reset");
        reset = 1'b0;
        rd(ADDR_COUNT,    32'd0,         "count_after_reset");
        rd(ADDR_CAUSE,    32'h0000_0000, "cause_after_reset");
        rd(ADDR_STATUS,   32'h0040_0000, "status_after_reset");
        rd(ADDR_EPC,      32'h0000_0000, "epc_after_reset");
        rd(ADDR_BADVADDR, 32'h0000_0000, "badvaddr_after_reset");
        rd(ADDR_COMPARE,  32'h0000_0000, "compare_after_reset");
        chk(1, 32'd0, "int_after_reset");

        idle_n(2);
        if (exp_q.size() != 0 || flush_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d/%0d pending want 0/0", exp_q.size(), flush_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
